// File: rtl/sqrt_pkg.sv
// Shared types and defaults for the sequential square-root unit.
// The FSM state encoding lives here so the top and any wrapper agree on it.
package sqrt_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_CW = 4;

    // Encoding 2'd3 is unused; the next-state logic steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/reg_en.sv
// N-bit enable-gated storage register with asynchronous active-low clear.
// When en is low the stored value holds.
module reg_en #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // NOTE: state registers use non-blocking assignments so every register in
    // the design samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sqrt_seq_unit.sv
// Restoring digit-by-digit integer square root: one root bit per clock,
// W/2 iterations, results held in enable-gated registers until the next start.
module sqrt_seq_unit
    import sqrt_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     radicand,
    output logic             busy,
    output logic             done,
    output logic [W/2-1:0]   root,
    output logic [W/2+1:0]   rem
);

    localparam int HW = W / 2;
    localparam int RW = HW + 2;

    logic [1:0]    state_q;
    state_t        state, state_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [HW-1:0] root_q, root_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic load_en, iter_en, dp_en;

    logic [RW-1:0] r_shift, trial, diff;
    logic          ge;

    assign state = state_t'(state_q);

    // NOTE: every signal driven in always_comb gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state;
        load_en = 1'b0;
        iter_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                iter_en = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bring down the next radicand digit pair and try subtracting 4*root+1.
    // The remainder never exceeds 2*root, so RW bits cannot overflow here.
    assign r_shift = {rem_q[HW-1:0], sh_q[W-1:W-2]};
    assign trial   = {root_q, 2'b01};
    assign ge      = (r_shift >= trial);
    assign diff    = r_shift - trial;

    assign dp_en = load_en | iter_en;

    always_comb begin
        sh_d   = sh_q << 2;
        root_d = {root_q[HW-2:0], ge};
        rem_d  = ge ? diff : r_shift;
        cnt_d  = cnt_q - CW'(1);
        if (load_en) begin
            sh_d   = radicand;
            root_d = '0;
            rem_d  = '0;
            cnt_d  = CW'(HW);
        end
    end

    reg_en #(.N(2)) u_state_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (state_d),
        .q     (state_q)
    );

    reg_en #(.N(W)) u_sh_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dp_en),
        .d     (sh_d),
        .q     (sh_q)
    );

    reg_en #(.N(HW)) u_root_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dp_en),
        .d     (root_d),
        .q     (root_q)
    );

    reg_en #(.N(RW)) u_rem_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dp_en),
        .d     (rem_d),
        .q     (rem_q)
    );

    reg_en #(.N(CW)) u_cnt_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dp_en),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign root = root_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_sqrt_seq_unit.sv
// Directed bench for sqrt_seq_unit (W=16): inputs driven and outputs sampled
// on the falling edge; expected values are hand-computed or from a search model.
module tb_sqrt_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] radicand;
    logic        busy;
    logic        done;
    logic [7:0]  root;
    logic [9:0]  rem;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_seq_unit #(.W(16), .CW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .radicand (radicand),
        .busy     (busy),
        .done     (done),
        .root     (root),
        .rem      (rem)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One job with a single-cycle start. lat counts falling edges after the
    // accepting edge until done; held drops if root/rem move after done.
    task automatic run_job(input logic [15:0] x, output logic [7:0] r,
                           output logic [9:0] m, output int lat,
                           output int busy_n, output int done_n,
                           output logic held);
        @(negedge clk);
        radicand = x;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = -1;
        busy_n = 0;
        done_n = 0;
        held   = 1'b1;
        r      = '0;
        m      = '0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                lat = i;
                r   = root;
                m   = rem;
            end else if (done_n > 0 && (root !== r || rem !== m)) begin
                held = 1'b0;
            end
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        radicand = '0;
        #3;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (root !== 8'd0) begin n_bad++; $display("FAIL reset_root: got %0d want 0", root); end
        n_cmp++; if (rem !== 10'd0) begin n_bad++; $display("FAIL reset_rem: got %0d want 0", rem); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
    endtask

    task automatic test_directed();
        logic [15:0] xs [7] = '{16'd144, 16'd200, 16'd1, 16'd0, 16'd65535, 16'd3, 16'd65024};
        logic [7:0]  rs [7] = '{8'd12, 8'd14, 8'd1, 8'd0, 8'd255, 8'd1, 8'd254};
        logic [9:0]  ms [7] = '{10'd0, 10'd4, 10'd0, 10'd0, 10'd510, 10'd2, 10'd508};
        logic [7:0]  r;
        logic [9:0]  m;
        int lat, bn, dn;
        logic held;
        for (int v = 0; v < 7; v++) begin
            run_job(xs[v], r, m, lat, bn, dn, held);
            n_cmp++; if (r !== rs[v]) begin n_bad++; $display("FAIL dir_root x=%0d: got %0d want %0d", xs[v], r, rs[v]); end
            n_cmp++; if (m !== ms[v]) begin n_bad++; $display("FAIL dir_rem x=%0d: got %0d want %0d", xs[v], m, ms[v]); end
            n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL dir_latency x=%0d: got %0d want 8", xs[v], lat); end
            n_cmp++; if (bn !== 9) begin n_bad++; $display("FAIL dir_busy_cycles x=%0d: got %0d want 9", xs[v], bn); end
            n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL dir_done_pulses x=%0d: got %0d want 1", xs[v], dn); end
            n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL dir_hold x=%0d: results moved after done", xs[v]); end
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (root !== 8'd254 || rem !== 10'd508) begin
            n_bad++; $display("FAIL idle_hold: got %0d/%0d want 254/508", root, rem);
        end
    endtask

    task automatic test_ignore_busy();
        int dn = 0;
        int i;
        @(negedge clk);
        radicand = 16'd144;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (i = 0; i < 40; i++) begin
            if (i == 3) begin start = 1'b1; radicand = 16'd50; end
            if (i == 4) start = 1'b0;
            if (done) begin
                dn++;
                n_cmp++; if (root !== 8'd12 || rem !== 10'd0) begin
                    n_bad++; $display("FAIL ignore_result: got %0d/%0d want 12/0", root, rem);
                end
            end
            if (!busy && i > 0) break;
            @(negedge clk);
        end
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL ignore_done_pulses: got %0d want 1", dn); end
    endtask

    task automatic test_back_to_back();
        int i;
        logic seen = 1'b0;
        @(negedge clk);
        radicand = 16'd144;
        start    = 1'b1;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen || root !== 8'd12 || rem !== 10'd0) begin
            n_bad++; $display("FAIL b2b_first: done=%b got %0d/%0d want 12/0", seen, root, rem);
        end
        radicand = 16'd200;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: busy=%b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept: busy=%b want 1", busy); end
        start = 1'b0;
        seen  = 1'b0;
        for (i = 1; i < 40; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen || i !== 8) begin n_bad++; $display("FAIL b2b_latency: seen=%b edges=%0d want 8", seen, i); end
        n_cmp++; if (root !== 8'd14 || rem !== 10'd4) begin
            n_bad++; $display("FAIL b2b_second: got %0d/%0d want 14/4", root, rem);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic [9:0] m;
        int lat, bn, dn;
        logic held;
        @(negedge clk);
        radicand = 16'd65535;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        // Four digit pairs of 0xFFFF: partial root 1111b, remainder 30.
        n_cmp++; if (root !== 8'd15 || rem !== 10'd30 || busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_partial: got %0d/%0d busy=%b want 15/30 busy=1", root, rem, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b want 0", done); end
        n_cmp++; if (root !== 8'd0) begin n_bad++; $display("FAIL mid_rst_root: got %0d want 0", root); end
        n_cmp++; if (rem !== 10'd0) begin n_bad++; $display("FAIL mid_rst_rem: got %0d want 0", rem); end
        @(negedge clk);
        rst_n = 1'b1;
        run_job(16'd99, r, m, lat, bn, dn, held);
        n_cmp++; if (r !== 8'd9 || m !== 10'd18) begin n_bad++; $display("FAIL post_rst_99: got %0d/%0d want 9/18", r, m); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL post_rst_latency: got %0d want 8", lat); end
    endtask

    task automatic test_sweep();
        logic [15:0] x;
        logic [7:0]  r;
        logic [9:0]  m;
        int lat, bn, dn, er, bad_here;
        logic held;
        for (int i = 0; i < 768; i++) begin
            case (i % 3)
                0:       x = 16'((i / 3) * (i / 3));
                1:       x = 16'((i / 3) * (i / 3) + 2 * (i / 3));
                default: x = 16'(i * 7919 + 13);
            endcase
            er = 0;
            while ((er + 1) * (er + 1) <= int'(x)) er++;
            run_job(x, r, m, lat, bn, dn, held);
            bad_here = 0;
            if (int'(r) != er) bad_here = 1;
            if (int'(m) != int'(x) - er * er) bad_here = 1;
            if (lat != 8 || dn != 1 || !held) bad_here = 1;
            n_cmp++; if (bad_here != 0) begin
                n_bad++;
                $display("FAIL sweep x=%0d: got %0d/%0d lat=%0d pulses=%0d held=%b want %0d/%0d lat=8 pulses=1 held=1",
                         x, r, m, lat, dn, held, er, int'(x) - er * er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
